// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU share arbiter: widths, opcodes and FSM encoding.
// Opcodes above OP_LUI are passed to the ALU untouched; the ALU decides what they mean.
package alu_ctrl_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int OP_WIDTH   = 4;

    localparam logic [OP_WIDTH-1:0] OP_AND = 4'd0;
    localparam logic [OP_WIDTH-1:0] OP_OR  = 4'd1;
    localparam logic [OP_WIDTH-1:0] OP_NOR = 4'd2;
    localparam logic [OP_WIDTH-1:0] OP_ADD = 4'd3;
    localparam logic [OP_WIDTH-1:0] OP_SUB = 4'd4;
    localparam logic [OP_WIDTH-1:0] OP_LUI = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port round-robin arbiter, purely combinational.
// On contention the port that was not granted last wins; a lone requester always wins.
module rr_arbiter2 (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (req0_i && req1_i) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end else if (req0_i) begin
            grant_o = 2'b01;
        end else if (req1_i) begin
            grant_o = 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters, one operation in flight.
//   state   | meaning
//   IDLE    | waiting for a request; grant, accept and latch operands
//   EXEC    | operands drive the ALU; result captured at cycle end
//   RESP    | response held for the granted port until it is consumed
module alu_share_arbiter #(
    parameter int DATA_WIDTH = alu_ctrl_pkg::DATA_WIDTH,
    parameter int OP_WIDTH   = alu_ctrl_pkg::OP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    output logic                  req0_ready,

    input  logic                  req1_valid,
    input  logic [OP_WIDTH-1:0]   req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  req1_ready,

    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_result,
    output logic                  rsp0_zero,
    input  logic                  rsp0_ready,

    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_result,
    output logic                  rsp1_zero,
    input  logic                  rsp1_ready,

    output logic [OP_WIDTH-1:0]   alu_operation,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero
);

    import alu_ctrl_pkg::*;

    state_e                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] rsp0_result_q, rsp0_result_d;
    logic [DATA_WIDTH-1:0] rsp1_result_q, rsp1_result_d;
    logic                  rsp0_zero_q, rsp0_zero_d;
    logic                  rsp1_zero_q, rsp1_zero_d;
    logic [1:0]            arb_grant;
    logic                  granted_rsp_ready;

    rr_arbiter2 u_rr_arbiter2 (
        .req0_i       (req0_valid),
        .req1_i       (req1_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant)
    );

    assign granted_rsp_ready = grant_q ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_zero_q   <= rsp1_zero_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        rsp0_result_d = rsp0_result_q;
        rsp1_result_d = rsp1_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp1_zero_d   = rsp1_zero_q;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        alu_operation = '0;
        alu_a         = '0;
        alu_b         = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Accept pulses are combinational, so reset must mask them directly.
                if (!reset && (arb_grant != 2'b00)) begin
                    req0_ready = arb_grant[0];
                    req1_ready = arb_grant[1];
                    grant_d    = arb_grant[1];
                    op_d       = arb_grant[1] ? req1_op : req0_op;
                    a_d        = arb_grant[1] ? req1_a  : req0_a;
                    b_d        = arb_grant[1] ? req1_b  : req0_b;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_operation = op_q;
                alu_a         = a_q;
                alu_b         = b_q;
                if (grant_q) begin
                    rsp1_result_d = alu_result;
                    rsp1_zero_d   = alu_zero;
                end else begin
                    rsp0_result_d = alu_result;
                    rsp0_zero_d   = alu_zero;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (granted_rsp_ready) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rsp0_valid  = (state_q == ST_RESP) && !grant_q;
    assign rsp1_valid  = (state_q == ST_RESP) &&  grant_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp1_zero   = rsp1_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of arbitration and the ALU.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero;
    logic        rsp0_ready, rsp1_ready;
    logic [3:0]  alu_operation;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;

    int tests  = 0;
    int failed = 0;
    int model_last = 1;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return ~(a | b);
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return {b[15:0], 16'h0000};
            default: return 32'h0;
        endcase
    endfunction

    // Stand-in for the shared combinational ALU.
    assign alu_result = alu_ref(alu_operation, alu_a, alu_b);
    assign alu_zero   = (alu_result == 32'h0);

    alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .rsp1_ready(rsp1_ready),
        .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 4'h0; req1_op = 4'h0;
        req0_a = 32'h0; req0_b = 32'h0; req1_a = 32'h0; req1_b = 32'h0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    function automatic logic [106:0] all_outputs();
        return {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero,
                rsp0_result, rsp1_result, alu_operation, alu_a[4:0]} |
               {75'h0, alu_a | alu_b};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        tests++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            failed++;
            $display("FAIL reset_dominates_valid: ready=%b expected 00", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
        #1;
        tests++;
        if (all_outputs() !== '0) begin
            failed++;
            $display("FAIL reset_outputs_zero: outputs=%h expected 0", all_outputs());
        end
        model_last = 1;
    endtask

    task automatic test_add();
        req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failed++;
            $display("FAIL add_accept: ready1,0=%b expected 01", {req1_ready, req0_ready});
        end
        step();
        req0_valid = 1'b0;
        tests++;
        if (rsp0_valid !== 1'b0 || alu_operation !== 4'd3 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
            failed++;
            $display("FAIL add_exec: rsp0_valid=%b op=%h a=%h b=%h expected 0 3 5 7",
                     rsp0_valid, alu_operation, alu_a, alu_b);
        end
        step();
        tests++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h0000000C || rsp0_zero !== 1'b0) begin
            failed++;
            $display("FAIL add_resp: valid=%b result=%h zero=%b expected 1 0000000c 0",
                     rsp0_valid, rsp0_result, rsp0_zero);
        end
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        tests++;
        if (rsp0_valid !== 1'b0 || alu_operation !== 4'd0 || alu_a !== 32'd0) begin
            failed++;
            $display("FAIL add_consumed: rsp0_valid=%b op=%h a=%h expected 0 0 0",
                     rsp0_valid, alu_operation, alu_a);
        end
        model_last = 0;
    endtask

    task automatic test_sub_port1();
        req1_valid = 1'b1; req1_op = 4'd4; req1_a = 32'd9; req1_b = 32'd9;
        #1;
        tests++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            failed++;
            $display("FAIL sub_accept: ready1,0=%b expected 10", {req1_ready, req0_ready});
        end
        step();
        req1_valid = 1'b0;
        step();
        tests++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h0 || rsp1_zero !== 1'b1 || rsp0_valid !== 1'b0) begin
            failed++;
            $display("FAIL sub_resp: rsp1_valid=%b result=%h zero=%b rsp0_valid=%b expected 1 0 1 0",
                     rsp1_valid, rsp1_result, rsp1_zero, rsp0_valid);
        end
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;
        model_last = 1;
    endtask

    task automatic test_contention();
        int grant_cycle[$];
        int grant_port[$];
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_last = 1;
        req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'd1; req0_b = 32'd2;
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'hF0; req1_b = 32'h0F;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req0_ready && req1_ready) begin
                tests++;
                failed++;
                $display("FAIL rr_double_ready: both ready at cycle %0d", c);
            end
            if (req0_ready) begin grant_cycle.push_back(c); grant_port.push_back(0); end
            if (req1_ready) begin grant_cycle.push_back(c); grant_port.push_back(1); end
            step();
        end
        idle_inputs();
        tests++;
        if (grant_port.size() != 4) begin
            failed++;
            $display("FAIL rr_grant_count: got %0d grants expected 4", grant_port.size());
        end else begin
            for (int g = 0; g < 4; g++) begin
                tests++;
                if (grant_port[g] != (g % 2) || grant_cycle[g] != 3 * g) begin
                    failed++;
                    $display("FAIL rr_grant_%0d: port=%0d cycle=%0d expected port=%0d cycle=%0d",
                             g, grant_port[g], grant_cycle[g], g % 2, 3 * g);
                end
            end
        end
        model_last = 1;
    endtask

    task automatic test_lui_hold();
        logic [31:0] exp1;
        req0_valid = 1'b1; req0_op = 4'd5; req0_a = 32'hDEAD; req0_b = 32'h00001234;
        req1_valid = 1'b1; req1_op = 4'd2; req1_a = 32'h0F0F0000; req1_b = 32'h000000FF;
        exp1 = alu_ref(4'd2, 32'h0F0F0000, 32'h000000FF);
        #1;
        tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failed++;
            $display("FAIL lui_accept: ready1,0=%b expected 01", {req1_ready, req0_ready});
        end
        step();
        req0_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h12340000 || req1_ready !== 1'b0 ||
                rsp1_valid !== 1'b0) begin
                failed++;
                $display("FAIL lui_hold_%0d: valid=%b result=%h req1_ready=%b rsp1_valid=%b expected 1 12340000 0 0",
                         i, rsp0_valid, rsp0_result, req1_ready, rsp1_valid);
            end
            step();
        end
        rsp0_ready = 1'b1;
        #1;
        tests++;
        if (req1_ready !== 1'b0) begin
            failed++;
            $display("FAIL lui_no_early_accept: req1_ready=%b expected 0", req1_ready);
        end
        step();
        rsp0_ready = 1'b0;
        #1;
        tests++;
        if (req1_ready !== 1'b1) begin
            failed++;
            $display("FAIL lui_req1_after_consume: req1_ready=%b expected 1", req1_ready);
        end
        step();
        req1_valid = 1'b0;
        step();
        tests++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== exp1 || rsp1_zero !== (exp1 == 32'h0)) begin
            failed++;
            $display("FAIL lui_req1_resp: valid=%b result=%h zero=%b expected 1 %h %b",
                     rsp1_valid, rsp1_result, rsp1_zero, exp1, exp1 == 32'h0);
        end
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;
        model_last = 1;
    endtask

    task automatic test_reset_in_exec();
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'hFF; req0_b = 32'h0F;
        step();
        req0_valid = 1'b0;
        step();
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 4'd3; req1_a = 32'd1; req1_b = 32'd2;
        step();
        req1_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        tests++;
        if (all_outputs() !== '0) begin
            failed++;
            $display("FAIL reset_exec_outputs: outputs=%h expected 0", all_outputs());
        end
        step();
        step();
        tests++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            failed++;
            $display("FAIL reset_exec_no_rsp: rsp0_valid=%b rsp1_valid=%b expected 0 0",
                     rsp0_valid, rsp1_valid);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failed++;
            $display("FAIL reset_exec_regrant: ready1,0=%b expected 01", {req1_ready, req0_ready});
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        model_last = 0;
    endtask

    task automatic test_unknown_op();
        req0_valid = 1'b1; req0_op = 4'hF; req0_a = 32'd1; req0_b = 32'd1;
        step();
        req0_valid = 1'b0;
        tests++;
        if (alu_operation !== 4'hF) begin
            failed++;
            $display("FAIL opF_forward: alu_operation=%h expected f", alu_operation);
        end
        step();
        tests++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h0 || rsp0_zero !== 1'b1) begin
            failed++;
            $display("FAIL opF_resp: valid=%b result=%h zero=%b expected 1 0 1",
                     rsp0_valid, rsp0_result, rsp0_zero);
        end
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        model_last = 0;
    endtask

    task automatic test_random();
        logic        v0, v1;
        int          exp_port, dly;
        logic [3:0]  op0, op1, exp_op;
        logic [31:0] a0, b0, a1, b1, exp_a, exp_b, exp_res, obs_res;
        logic        obs_zero, obs_valid, oth_valid;
        for (int it = 0; it < 30; it++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) begin
                if ($urandom_range(0, 1) == 0) v0 = 1'b1; else v1 = 1'b1;
            end
            op0 = 4'($urandom_range(0, 15)); a0 = $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            op1 = 4'($urandom_range(0, 15)); a1 = $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            dly = $urandom_range(0, 2);
            exp_port = (v0 && v1) ? ((model_last == 1) ? 0 : 1) : (v0 ? 0 : 1);
            exp_op = exp_port ? op1 : op0;
            exp_a  = exp_port ? a1 : a0;
            exp_b  = exp_port ? b1 : b0;
            exp_res = alu_ref(exp_op, exp_a, exp_b);

            req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
            req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
            #1;
            tests++;
            if ({req1_ready, req0_ready} !== (exp_port ? 2'b10 : 2'b01)) begin
                failed++;
                $display("FAIL rnd%0d_grant: ready1,0=%b expected port %0d", it,
                         {req1_ready, req0_ready}, exp_port);
            end
            step();
            req0_valid = 1'b0; req1_valid = 1'b0;
            tests++;
            if (alu_operation !== exp_op || alu_a !== exp_a || alu_b !== exp_b) begin
                failed++;
                $display("FAIL rnd%0d_exec: op=%h a=%h b=%h expected %h %h %h", it,
                         alu_operation, alu_a, alu_b, exp_op, exp_a, exp_b);
            end
            step();
            if (exp_port == 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
            for (int d = 0; d <= dly; d++) begin
                obs_valid = exp_port ? rsp1_valid : rsp0_valid;
                oth_valid = exp_port ? rsp0_valid : rsp1_valid;
                obs_res   = exp_port ? rsp1_result : rsp0_result;
                obs_zero  = exp_port ? rsp1_zero : rsp0_zero;
                tests++;
                if (obs_valid !== 1'b1 || oth_valid !== 1'b0 || obs_res !== exp_res ||
                    obs_zero !== (exp_res == 32'h0) || alu_operation !== 4'h0 || alu_a !== 32'h0) begin
                    failed++;
                    $display("FAIL rnd%0d_resp%0d: valid=%b other=%b result=%h zero=%b expected 1 0 %h %b",
                             it, d, obs_valid, oth_valid, obs_res, obs_zero, exp_res, exp_res == 32'h0);
                end
                if (d < dly) step();
            end
            rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            step();
            rsp0_ready = 1'b0; rsp1_ready = 1'b0;
            tests++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                failed++;
                $display("FAIL rnd%0d_consumed: rsp0_valid=%b rsp1_valid=%b expected 0 0",
                         it, rsp0_valid, rsp1_valid);
            end
            model_last = exp_port;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_add();
        test_sub_port1();
        test_contention();
        test_lui_hold();
        test_reset_in_exec();
        test_unknown_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
